// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: button indices, navigation state encoding and default timing
package button_conditioner_pkg;
    localparam int unsigned NUM_BTN    = 5;
    localparam int unsigned BTN_CANCEL = 0;
    localparam int unsigned BTN_TEST   = 1;
    localparam int unsigned BTN_ACTIVE = 2;
    localparam int unsigned BTN_LEFT   = 3;
    localparam int unsigned BTN_RIGHT  = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_HOLD_CYCLES     = 25_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;
    typedef enum logic [1:0] {
        NAV_IDLE      = 2'd0,
        NAV_HELD_WAIT = 2'd1,
        NAV_REPEAT    = 2'd2
    } nav_state_e;
endpackage

// File: rtl/button_conditioner_debounce.sv
// btn_debounce: 2-flop synchroniser, counter debouncer and press/release pulser for one button.
// The *_d outputs announce the edge about to be registered so the top can act in the same cycle.
module btn_debounce
    import button_conditioner_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic rise_d_o,
    output logic fall_d_o,
    output logic level_d_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync_q;
    logic          stable_q, stable_d, press_q, release_q, flip;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        flip     = (sync_q[1] != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES));
        stable_d = stable_q ^ flip;
        cnt_d    = (sync_q[1] == stable_q || flip) ? '0 : cnt_q + CW'(cnt_q != CW'(DEBOUNCE_CYCLES));
    end
    // Polarity is folded in ahead of the synchroniser so reset (all zero) means released.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw_i ^ ACTIVE_LOW};
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= flip & ~stable_q;
            release_q <= flip & stable_q;
        end
    end
    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign rise_d_o  = flip & ~stable_q;
    assign fall_d_o  = flip & stable_q;
    assign level_d_o = stable_d;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: five debounced buttons plus left/right menu stepping with auto-repeat.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       btn_reset,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic [1:0] nav_step
);
    localparam int TW = $clog2((HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES) + 1);
    logic [4:0] rise_d, fall_d, level_d;
    logic       both_held, unused_ok;
    for (genvar c = 0; c < NUM_BTN; c++) begin : g_btn
        btn_debounce #(
            .ACTIVE_LOW     (BTN_ACTIVE_LOW),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i    (clk),
            .rst_i    (btn_reset),
            .raw_i    (btn_raw[c]),
            .level_o  (btn_level[c]),
            .press_o  (btn_press[c]),
            .release_o(btn_release[c]),
            .rise_d_o (rise_d[c]),
            .fall_d_o (fall_d[c]),
            .level_d_o(level_d[c])
        );
    end
    assign unused_ok = ^{rise_d[2:0], fall_d[2:0], level_d[2:0]};
    // Judged on next-cycle levels so a simultaneous or overlapping press never steps.
    assign both_held = level_d[BTN_LEFT] & level_d[BTN_RIGHT];
    for (genvar g = 0; g < 2; g++) begin : g_nav
        localparam int unsigned B = (g == 0) ? BTN_LEFT : BTN_RIGHT;
        nav_state_e    state_q;
        logic [TW-1:0] timer_q;
        logic          step_q;
        always_ff @(posedge clk or posedge btn_reset) begin
            if (btn_reset) begin
                state_q <= NAV_IDLE;
                timer_q <= '0;
                step_q  <= 1'b0;
            end else if (both_held || fall_d[B]) begin
                state_q <= NAV_IDLE;
                timer_q <= '0;
                step_q  <= 1'b0;
            end else begin
                step_q <= 1'b0;
                case (state_q)
                    NAV_IDLE: begin
                        timer_q <= '0;
                        if (rise_d[B]) begin
                            state_q <= NAV_HELD_WAIT;
                            step_q  <= 1'b1;
                        end
                    end
                    NAV_HELD_WAIT: begin
                        if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                            state_q <= NAV_REPEAT;
                            timer_q <= '0;
                            step_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TW'(timer_q != '1);
                        end
                    end
                    NAV_REPEAT: begin
                        if (timer_q == TW'(REPEAT_CYCLES - 1)) begin
                            timer_q <= '0;
                            step_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TW'(timer_q != '1);
                        end
                    end
                    default: begin
                        state_q <= NAV_IDLE;
                        timer_q <= '0;
                    end
                endcase
            end
        end
        assign nav_step[g] = step_q;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce latency, glitch rejection, nav repeat and reset,
// followed by a randomised toggle phase compared against a fixed-latency level model.
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       btn_reset = 1'b1;
    logic [4:0] btn_raw = 5'h1F;
    logic [4:0] btn_level, btn_press, btn_release;
    logic [1:0] nav_step;
    int total = 0;
    int bad = 0;
    int pc[5];
    int rc[5];

    button_conditioner #(
        .BTN_ACTIVE_LOW (1'b1),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk        (clk),
        .btn_reset  (btn_reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .nav_step   (nav_step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 5; b++) begin
            if (btn_press[b]) pc[b]++;
            if (btn_release[b]) rc[b]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [4:0] q[$];
        logic [4:0] v;
        int age[5];
        int p0[5];
        int r0[5];
        int rises[5];
        for (int b = 0; b < 5; b++) begin pc[b] = 0; rc[b] = 0; end

        // reset state
        step(2);
        chk("reset_outputs", {btn_level, btn_press, btn_release, nav_step}, 0);
        btn_reset = 1'b0;
        step(10);
        chk("idle_outputs", {btn_level, btn_press, btn_release, nav_step}, 0);

        // action press/release latency
        btn_raw[2] = 1'b0;
        step(6);
        chk("act_level_pre", btn_level, 5'h00);
        step(1);
        chk("act_level_rise", btn_level, 5'h04);
        chk("act_press", btn_press, 5'h04);
        chk("act_nav", nav_step, 2'b00);
        step(1);
        chk("act_press_once", btn_press, 5'h00);
        btn_raw[2] = 1'b1;
        step(6);
        chk("act_level_held", btn_level, 5'h04);
        chk("act_rel_pre", btn_release, 5'h00);
        step(1);
        chk("act_release", btn_release, 5'h04);
        chk("act_level_fall", btn_level, 5'h00);
        step(1);
        chk("act_release_once", btn_release, 5'h00);
        step(4);

        // short glitch on left
        btn_raw[3] = 1'b0;
        step(3);
        btn_raw[3] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1);
            chk("glitch_quiet", {btn_level, btn_press, nav_step}, 0);
        end

        // right held: step at press, +20, then every 8
        btn_raw[4] = 1'b0;
        step(7);
        chk("rep_press", btn_press, 5'h10);
        chk("rep_nav0", nav_step, 2'b10);
        for (int k = 1; k <= 75; k++) begin
            if (k == 61) btn_raw[4] = 1'b1;
            step(1);
            chk("rep_nav", nav_step, (k == 20 || (k > 20 && k <= 60 && (k - 20) % 8 == 0)) ? 2'b10 : 2'b00);
            if (k == 67) chk("rep_release", btn_release, 5'h10);
        end

        // left then right overlap: both held suppresses, survivor stays quiet
        btn_raw[3] = 1'b0;
        step(7);
        chk("ov_left_nav", nav_step, 2'b01);
        step(3);
        btn_raw[4] = 1'b0;
        for (int k = 4; k < 44; k++) begin
            step(1);
            chk("ov_both_nav", nav_step, 2'b00);
            if (k == 10) chk("ov_both_level", btn_level, 5'h18);
        end
        btn_raw[4] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step(1);
            chk("ov_survivor_nav", nav_step, 2'b00);
        end
        chk("ov_left_level", btn_level, 5'h08);
        btn_raw[3] = 1'b1;
        step(7);
        chk("ov_left_release", btn_release, 5'h08);
        step(3);
        btn_raw[3] = 1'b0;
        step(7);
        chk("ov_left_repress", nav_step, 2'b01);
        btn_raw[3] = 1'b1;
        step(10);

        // simultaneous press
        btn_raw = 5'h07;
        step(7);
        chk("sim_press", btn_press, 5'h18);
        chk("sim_nav0", nav_step, 2'b00);
        for (int k = 0; k < 30; k++) begin
            step(1);
            chk("sim_nav", nav_step, 2'b00);
        end
        btn_raw = 5'h1F;
        step(10);

        // reset mid-repeat with right held
        btn_raw[4] = 1'b0;
        step(7);
        chk("rst_press", nav_step, 2'b10);
        step(25);
        btn_reset = 1'b1;
        #1;
        chk("rst_async", {btn_level, btn_press, btn_release, nav_step}, 0);
        step(3);
        chk("rst_hold", {btn_level, btn_press, btn_release, nav_step}, 0);
        btn_reset = 1'b0;
        step(6);
        chk("rst_pre_press", {btn_press, nav_step}, 0);
        step(1);
        chk("rst_press_again", btn_press, 5'h10);
        chk("rst_nav_again", nav_step, 2'b10);
        step(1);
        chk("rst_press_once", btn_press, 5'h00);
        btn_raw[4] = 1'b1;
        step(12);

        // random debounce-valid toggling against a 6-edge latency model
        for (int b = 0; b < 5; b++) begin
            age[b] = 100; p0[b] = pc[b]; r0[b] = rc[b]; rises[b] = 0;
        end
        v = 5'h1F;
        for (int k = 0; k < 6; k++) q.push_back(5'h00);
        for (int i = 0; i < 640; i++) begin
            for (int b = 0; b < 5; b++) begin
                age[b]++;
                if (age[b] >= 8 && (i < 600 ? $urandom_range(0, 9) == 0 : v[b] == 1'b0)) begin
                    v[b] = ~v[b];
                    age[b] = 0;
                end
            end
            btn_raw = v;
            q.push_back(~v);
            step(1);
            chk("rand_level", btn_level, q[q.size() - 7]);
        end
        for (int k = 1; k < q.size(); k++)
            for (int b = 0; b < 5; b++)
                if (q[k][b] && !q[k-1][b]) rises[b]++;
        step(2);
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("rand_press_count%0d", b), pc[b] - p0[b], rises[b]);
            chk($sformatf("rand_release_count%0d", b), rc[b] - r0[b], pc[b] - p0[b]);
        end
        chk("rand_final_level", btn_level, 5'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The parameters SHALL be:
- BTN_ACTIVE_LOW, default 1: raw buttons read 0 when pressed.
- DEBOUNCE_CYCLES, default 1_000_000: stable cycles required (20 ms at 50 MHz).
- HOLD_CYCLES, default 25_000_000: cycles from press to first auto-repeat.
- REPEAT_CYCLES, default 10_000_000: cycles between later repeats.
REQ-002 The design SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-003 The ports SHALL be:
- clk  input  1  system clock, 50 MHz.
- btn_reset  input  1  asynchronous active-high reset.
- btn_raw  input  5  unsynchronised pins: bit0 cancel, bit1 test, bit2 action, bit3 left, bit4 right.
- btn_level  output  5  debounced pressed level, active-high.
- btn_press  output  5  one-cycle pulse on each debounced press.
- btn_release  output  5  one-cycle pulse on each debounced release.
- nav_step  output  2  one-cycle menu-step pulses: bit0 left, bit1 right; includes auto-repeats.

Function
REQ-004 Each btn_raw bit SHALL pass through a 2-flop synchroniser, then be inverted when BTN_ACTIVE_LOW=1.
REQ-005 Each channel SHALL update its stable level only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any cycle where they match SHALL clear that channel's counter.
REQ-006 Latency: let cycle 0 be the first clk edge that samples a new raw level. btn_level SHALL change at edge DEBOUNCE_CYCLES+2 if the raw level stays constant.
REQ-007 btn_press (btn_release) SHALL be high for exactly the one cycle in which btn_level rises (falls); btn_level SHALL never rise and fall in the same cycle.
REQ-008 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no btn_level change and no pulse.
REQ-009 Each navigation channel (left, right) SHALL have a state machine with states IDLE, HELD_WAIT, REPEAT:
- IDLE -> HELD_WAIT on btn_press, with nav_step pulsed and the repeat timer cleared.
- HELD_WAIT -> REPEAT when the timer reaches HOLD_CYCLES-1, with nav_step pulsed and the timer cleared.
- REPEAT pulses nav_step every REPEAT_CYCLES cycles.
- Any state -> IDLE on btn_release, with no pulse.
REQ-010 While both the left and right btn_level are high:
- nav_step SHALL be 2'b00.
- Both navigation state machines SHALL be forced to IDLE with timers cleared.
- When one button is released, the one still held SHALL NOT step until it is pressed again.
REQ-011 If left and right btn_press occur in the same cycle, no nav_step SHALL be emitted.
REQ-012 Channels 0-2 SHALL have no auto-repeat; only btn_press and btn_release apply to them.
REQ-013 Each counter SHALL be $clog2(max parameter + 1) bits wide and saturate rather than wrap. All parameters SHALL be >= 2; smaller values are illegal.
REQ-014 All outputs SHALL be registered, with no combinational path from btn_raw.

Reset
REQ-015 While btn_reset=1, the following SHALL hold asynchronously:
- synchroniser flops, stable levels, counters and timers SHALL be 0 (released state);
- navigation state machines SHALL be IDLE;
- btn_level, btn_press, btn_release and nav_step SHALL be 0.
REQ-016 When reset is deasserted while a button is physically held, a full debounce SHALL run, followed by a normal btn_press; no pulse SHALL be lost or duplicated.
REQ-017 Reset asserted mid-debounce or mid-repeat SHALL abort the operation, with no pulse emitted in that cycle.

Structure
REQ-018 A shared package SHALL hold the button index constants (BTN_CANCEL=0, BTN_TEST=1, BTN_ACTIVE=2, BTN_LEFT=3, BTN_RIGHT=4), the navigation state encoding, and the default timing constants.
REQ-019 The per-channel synchroniser, debouncer and edge pulser SHALL be one sub-module, btn_debounce, instantiated 5 times. The repeat state machines and left/right arbitration SHALL remain in button_conditioner.

Verification
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8 and BTN_ACTIVE_LOW=1.
REQ-020 Drive action bit 1->0 and hold: btn_level[2] rises at edge 6 and btn_press[2] is high for that single cycle; releasing gives btn_release[2] 6 edges after the release.
REQ-021 Drive left low for 3 cycles, then high: no btn_level, btn_press or nav_step activity.
REQ-022 Hold right for 60 cycles after debounce: nav_step[1] pulses at press, press+20, press+28, press+36 and so on, and stops on release.
REQ-023 Press left, then press right 10 cycles later: nav_step stays 0 while both are held. Release right: left emits no step until it is released and pressed again.
REQ-024 Assert btn_reset mid-repeat with right held: all outputs 0 immediately. After deassertion: btn_press[4] and nav_step[1] follow after 6 edges.
REQ-025 Toggle all 5 raw bits randomly with debounce-valid widths: for every channel, presses equal releases and btn_level always matches the model.
